// File: rtl/conv2d_kernel_scheduler.sv
// Layer sequencer for one conv2d layer: walks output channels (kernel loads) and
// input channels (MAC passes), stepping the kernel read address and flushing per kernel.
module conv2d_kernel_scheduler #(
   parameter int CH_W     = 9,
   parameter int UPD_WAIT = 3
) (
   input  logic            clk,
   input  logic            Reset,
   input  logic            start,
   input  logic [CH_W-1:0] cfg_in_channels,
   input  logic [CH_W-1:0] cfg_out_channels,
   input  logic            done_loading_1ker,
   input  logic            last_channel,
   input  logic            conv_done,
   input  logic            flush_ack,
   output logic            load_BRAM_dina,
   output logic            update_BRAM_doutb,
   output logic            conv_start,
   output logic            acc_clear,
   output logic            acc_flush,
   output logic [CH_W-1:0] oc_index,
   output logic [CH_W-1:0] ic_index,
   output logic            busy,
   output logic            done,
   output logic            sched_err
);

   localparam int              HOLD_W    = (UPD_WAIT > 1) ? $clog2(UPD_WAIT) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(UPD_WAIT - 1);
   localparam logic [CH_W-1:0]   ONE       = CH_W'(1);

   typedef enum logic [3:0] {
      S_IDLE,
      S_LOAD,
      S_WAIT_LOAD,
      S_SETTLE,
      S_CLR,
      S_CONV,
      S_WAIT_CONV,
      S_UPD,
      S_UPD_HOLD,
      S_FLUSH,
      S_DONE
   } state_t;

   state_t            state;
   state_t            state_n;
   logic [CH_W-1:0]   n_lat;
   logic [CH_W-1:0]   m_lat;
   logic [HOLD_W-1:0] hold_cnt;
   logic              last_flag;

   logic start_ok;
   logic cfg_zero;
   logic ic_last;
   logic oc_last;
   logic hold_end;
   logic flush_done;
   logic last_seen;

   logic load_d;
   logic upd_d;
   logic conv_d;
   logic clr_d;
   logic flush_d;
   logic busy_d;
   logic done_d;

   assign start_ok   = (state == S_IDLE) && start;
   assign cfg_zero   = (cfg_in_channels == '0) || (cfg_out_channels == '0);
   assign ic_last    = (ic_index + ONE) == n_lat;
   assign oc_last    = (oc_index + ONE) == m_lat;
   assign hold_end   = (state == S_UPD_HOLD) && (hold_cnt == HOLD_LAST);
   assign flush_done = (state == S_FLUSH) && flush_ack;
   // last_channel on the final hold cycle still counts toward the flag
   assign last_seen  = last_flag | last_channel;

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) state <= S_IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         S_IDLE:      if (start) state_n = cfg_zero ? S_DONE : S_LOAD;
         S_LOAD:      state_n = S_WAIT_LOAD;
         S_WAIT_LOAD: if (done_loading_1ker) state_n = S_SETTLE;
         S_SETTLE:    state_n = S_CLR;
         S_CLR:       state_n = S_CONV;
         S_CONV:      state_n = S_WAIT_CONV;
         S_WAIT_CONV: if (conv_done) state_n = S_UPD;
         S_UPD:       state_n = S_UPD_HOLD;
         S_UPD_HOLD:  if (hold_end) state_n = ic_last ? S_FLUSH : S_CONV;
         S_FLUSH:     if (flush_ack) state_n = oc_last ? S_DONE : S_LOAD;
         S_DONE:      state_n = S_IDLE;
         default:     state_n = S_IDLE;
      endcase
   end

   always_comb begin
      load_d  = (state == S_LOAD);
      upd_d   = (state == S_UPD);
      conv_d  = (state == S_CONV);
      clr_d   = (state == S_CLR);
      done_d  = (state == S_DONE);
      busy_d  = (state != S_IDLE) && (state != S_DONE);
      // flush level tracks the FLUSH state itself so it drops with the accepted ack
      flush_d = (state_n == S_FLUSH);
   end

   // registered command outputs, one cycle behind the state that issues them
   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         load_BRAM_dina    <= 1'b0;
         update_BRAM_doutb <= 1'b0;
         conv_start        <= 1'b0;
         acc_clear         <= 1'b0;
         acc_flush         <= 1'b0;
         busy              <= 1'b0;
         done              <= 1'b0;
      end else begin
         load_BRAM_dina    <= load_d;
         update_BRAM_doutb <= upd_d;
         conv_start        <= conv_d;
         acc_clear         <= clr_d;
         acc_flush         <= flush_d;
         busy              <= busy_d;
         done              <= done_d;
      end
   end

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         oc_index  <= '0;
         ic_index  <= '0;
         sched_err <= 1'b0;
      end else if (start_ok) begin
         oc_index  <= '0;
         ic_index  <= '0;
         sched_err <= 1'b0;
      end else if (hold_end) begin
         if (last_seen != ic_last) sched_err <= 1'b1;
         if (!ic_last)             ic_index  <= ic_index + ONE;
      end else if (flush_done) begin
         ic_index <= '0;
         oc_index <= oc_index + ONE;
      end
   end

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         hold_cnt  <= '0;
         last_flag <= 1'b0;
      end else if (state == S_UPD) begin
         hold_cnt  <= '0;
         last_flag <= 1'b0;
      end else if (state == S_UPD_HOLD) begin
         hold_cnt  <= hold_cnt + HOLD_W'(1);
         last_flag <= last_seen;
      end
   end

   // layer dimensions are pure data, only meaningful after an accepted start
   always_ff @(posedge clk) begin
      if (start_ok) begin
         n_lat <= cfg_in_channels;
         m_lat <= cfg_out_channels;
      end
   end

endmodule
